// File: rtl/tx_ram_reader_pkg.sv
// Shared definitions for the TX buffer-RAM reader: RAM word field offsets and FSM states.
package tx_ram_reader_pkg;

  // Control-field offsets above the data field; a RAM word is {sop, eop, be[1:0], data}.
  localparam int SOP_BIT = 3;
  localparam int EOP_BIT = 2;
  localparam int BE_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

endpackage

// File: rtl/tx_ram_reader_if.sv
// Framed output stream (data/sop/eop/be with valid/ready) leaving the TX RAM reader.
interface tx_ram_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;
  logic [1:0]            be;
  logic                  valid;
  logic                  ready;

  modport master (output data, sop, eop, be, valid, input ready);
  modport slave  (input data, sop, eop, be, valid, output ready);
endinterface

// File: rtl/tx_skid_buf2.sv
// Two-entry output buffer; the head register drives the stream and only moves on a pop.
module tx_skid_buf2 #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;

  // Producer never pushes into a full buffer unless the head is popping in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail  <= push_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/tx_ram_reader.sv
// Reads framed words from the TX buffer RAM and streams them out with frame filtering.
// Optional macro TX_RAM_READER_DROP_EN adds a frame_drop input and the DROP state.
//
// state     | meaning
// ST_IDLE   | waiting for a sop word; other words are discarded
// ST_STREAM | forwarding words of the current frame until its eop word
// ST_DROP   | discarding the remainder of an aborted frame up to its eop word
module tx_ram_reader
  import tx_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [RAM_WIDTH-1:0]  ram_q,
`ifdef TX_RAM_READER_DROP_EN
  input  logic                  frame_drop,
`endif
  tx_ram_reader_if.master       tx,
  output logic [15:0]           frame_cnt
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   fetch_ptr;
  logic                  inflight;
  logic                  keep;
  logic                  flush;
  logic                  fetch;
  logic                  pop;
  logic [2:0]            occ;
  logic [1:0]            sk_count;
  logic [RAM_WIDTH-1:0]  head;
  logic [ADDR_WIDTH:0]   retire;
  logic                  w_sop;
  logic                  w_eop;

  assign w_sop = ram_q[DATA_WIDTH+SOP_BIT];
  assign w_eop = ram_q[DATA_WIDTH+EOP_BIT];

  assign tx.valid = (sk_count != 2'd0);
  assign tx.data  = head[DATA_WIDTH-1:0];
  assign tx.sop   = head[DATA_WIDTH+SOP_BIT];
  assign tx.eop   = head[DATA_WIDTH+EOP_BIT];
  assign tx.be    = head[DATA_WIDTH+BE_LSB +: 2];
  assign pop      = tx.valid && tx.ready;

  // Occupancy counts the slot freed by this cycle's pop so a steady stream runs one word per clock.
  assign occ      = {1'b0, sk_count} + {2'b00, inflight} - {2'b00, pop};
  assign fetch    = (fetch_ptr != wr_ptr) && (occ < 3'd2);
  assign ram_addr = fetch_ptr[ADDR_WIDTH-1:0];

  // Words retire to the writer when accepted downstream or discarded, never at fetch time.
  assign retire = (flush ? {{(ADDR_WIDTH-1){1'b0}}, sk_count} : {{ADDR_WIDTH{1'b0}}, pop})
                + {{ADDR_WIDTH{1'b0}}, inflight & ~keep};

  always_comb begin
    state_nxt = state;
    keep      = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inflight && w_sop) begin
          keep      = 1'b1;
          state_nxt = w_eop ? ST_IDLE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (inflight) begin
          keep = 1'b1;
          if (w_eop) state_nxt = ST_IDLE;
        end
`ifdef TX_RAM_READER_DROP_EN
        if (frame_drop) begin
          keep      = 1'b0;
          flush     = 1'b1;
          state_nxt = (inflight && w_eop) ? ST_IDLE : ST_DROP;
        end
`endif
      end
`ifdef TX_RAM_READER_DROP_EN
      ST_DROP: begin
        if (inflight && w_eop) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      fetch_ptr <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      frame_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fetch;
      rd_ptr   <= rd_ptr + retire;
      if (fetch) fetch_ptr <= fetch_ptr + 1'b1;
      if (pop && head[DATA_WIDTH+EOP_BIT]) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  tx_skid_buf2 #(.WIDTH(RAM_WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (inflight && keep),
    .push_data (ram_q),
    .pop       (pop),
    .head      (head),
    .count     (sk_count)
  );

endmodule

// File: tb/tb_tx_ram_reader.sv
// Self-checking bench for tx_ram_reader: behavioural RAM, writer pointer and scoreboard queue.
module tb_tx_ram_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  wr_ptr = '0;
  logic [8:0]  rd_ptr;
  logic [7:0]  ram_addr;
  logic [35:0] ram_q;
  logic        frame_drop = 1'b0;
  logic [15:0] frame_cnt;
  logic [35:0] mem [256];

  logic [35:0] sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          xfers   = 0;
  bit          saw_eop = 0;
  bit          hold_chk = 0;
  logic [35:0] prev_word;

  tx_ram_reader_if #(.DATA_WIDTH(32)) tx_if ();

  tx_ram_reader dut (
    .clk       (clk),
    .reset     (reset),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
`ifdef TX_RAM_READER_DROP_EN
    .frame_drop(frame_drop),
`endif
    .tx        (tx_if),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: drive ready at the falling edge, then check hold and any transfer at the next rising edge.
  task automatic step(input bit rdy);
    logic [35:0] got;
    logic [35:0] exp;
    @(negedge clk);
    tx_if.ready = rdy;
    #1;
    got = {tx_if.sop, tx_if.eop, tx_if.be, tx_if.data};
    if (hold_chk) begin
      n_tests++;
      if (tx_if.valid !== 1'b1 || got !== prev_word) begin
        n_fail++;
        $display("FAIL hold: valid=%b word=%h required valid=1 word=%h", tx_if.valid, got, prev_word);
      end
    end
    if (tx_if.valid && rdy) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h, required no transfer", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL word: got %h required %h", got, exp);
        end
      end
      if (tx_if.eop) saw_eop = 1;
      xfers++;
    end
    hold_chk  = tx_if.valid && !rdy;
    prev_word = got;
  endtask

  task automatic put(input logic s, input logic e, input logic [1:0] b, input bit expect_out);
    logic [35:0] w;
    w = {s, e, b, 32'($urandom)};
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 9'd1;
    if (expect_out) sb.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tx_if.ready = 1'b0;
    frame_drop = 1'b0;
    wr_ptr = '0;
    sb.delete();
    hold_chk = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // mode 0: ready high, 1: ready toggles 1/0, 2: random ready
  task automatic drain(input int mode, input int budget, input string name);
    int n;
    bit r;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      step(r);
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, sb.size());
    end
    repeat (4) step(1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 8;
    if (tx_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", tx_if.valid); end
    if (tx_if.sop !== 1'b0)   begin n_fail++; $display("FAIL rst_sop: got %b required 0", tx_if.sop); end
    if (tx_if.eop !== 1'b0)   begin n_fail++; $display("FAIL rst_eop: got %b required 0", tx_if.eop); end
    if (tx_if.be !== 2'd0)    begin n_fail++; $display("FAIL rst_be: got %0d required 0", tx_if.be); end
    if (tx_if.data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h required 0", tx_if.data); end
    if (frame_cnt !== 16'd0)  begin n_fail++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
    if (rd_ptr !== 9'd0)      begin n_fail++; $display("FAIL rst_rd_ptr: got %0d required 0", rd_ptr); end
    if (ram_addr !== 8'd0)    begin n_fail++; $display("FAIL rst_ram_addr: got %0d required 0", ram_addr); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    xfers = 0;
    put(1, 0, 2'd0, 1);
    put(0, 0, 2'd0, 1);
    put(0, 1, 2'd2, 1);
    step(1'b1);
    step(1'b1);
    n_tests++;
    if (xfers !== 1) begin n_fail++; $display("FAIL basic_latency: %0d transfers after 2 clk, required 1", xfers); end
    step(1'b1);
    step(1'b1);
    n_tests++;
    if (xfers !== 3) begin n_fail++; $display("FAIL basic_back_to_back: %0d transfers after 4 clk, required 3", xfers); end
    step(1'b1);
    step(1'b1);
    n_tests += 3;
    if (sb.size() != 0) begin n_fail++; $display("FAIL basic_left: %0d words outstanding, required 0", sb.size()); end
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d required 1", frame_cnt); end
    if (rd_ptr !== 9'd3) begin n_fail++; $display("FAIL basic_rd_ptr: got %0d required 3", rd_ptr); end
  endtask

  task automatic test_full_wrap_backpressure();
    do_reset();
    for (int i = 0; i < 256; i++) put(i == 0, i == 255, (i == 255) ? 2'd3 : 2'd0, 1);
    drain(1, 1200, "full");
    n_tests += 2;
    if (rd_ptr !== 9'h100) begin n_fail++; $display("FAIL full_rd_ptr: got %h required 100", rd_ptr); end
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL full_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_single_word_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 255; i++) put(0, 0, 2'd0, 0);
    n = 0;
    while (rd_ptr != 9'd255 && n < 400) begin
      step(1'b1);
      n++;
    end
    n_tests++;
    if (rd_ptr !== 9'd255) begin n_fail++; $display("FAIL wrap_stray_rd_ptr: got %0d required 255", rd_ptr); end
    put(1, 1, 2'd1, 1);
    put(1, 0, 2'd0, 1);
    put(0, 1, 2'd3, 1);
    drain(0, 40, "wrap");
    n_tests += 2;
    if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_frame_cnt: got %0d required 2", frame_cnt); end
    if (rd_ptr !== 9'h102) begin n_fail++; $display("FAIL wrap_rd_ptr: got %h required 102", rd_ptr); end
  endtask

  task automatic test_reset_midframe();
    int n;
    do_reset();
    xfers = 0;
    saw_eop = 0;
    put(1, 0, 2'd0, 1);
    put(0, 0, 2'd0, 1);
    put(0, 0, 2'd0, 1);
    put(0, 1, 2'd1, 1);
    n = 0;
    while (xfers < 2 && n < 20) begin
      step(1'b1);
      n++;
    end
    n_tests++;
    if (xfers !== 2) begin n_fail++; $display("FAIL midrst_xfers: got %0d required 2", xfers); end
    @(negedge clk);
    reset = 1'b1;
    tx_if.ready = 1'b0;
    wr_ptr = '0;
    sb.delete();
    hold_chk = 0;
    @(negedge clk);
    #1;
    n_tests += 2;
    if (tx_if.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", tx_if.valid); end
    if (rd_ptr !== 9'd0) begin n_fail++; $display("FAIL midrst_rd_ptr: got %0d required 0", rd_ptr); end
    reset = 1'b0;
    repeat (6) step(1'b1);
    n_tests += 2;
    if (saw_eop !== 1'b0) begin n_fail++; $display("FAIL midrst_eop: eop seen=%b required 0", saw_eop); end
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d required 0", frame_cnt); end
  endtask

  task automatic test_truncate_random_ready();
    do_reset();
    put(1, 0, 2'd0, 1);
    put(0, 0, 2'd0, 1);
    put(1, 1, 2'd2, 1);
    put(1, 0, 2'd0, 1);
    put(0, 1, 2'd0, 1);
    drain(2, 200, "trunc");
    n_tests += 2;
    if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL trunc_frame_cnt: got %0d required 2", frame_cnt); end
    if (rd_ptr !== 9'd5) begin n_fail++; $display("FAIL trunc_rd_ptr: got %0d required 5", rd_ptr); end
  endtask

  task automatic test_stray_word();
    do_reset();
    put(0, 0, 2'd0, 0);
    put(0, 1, 2'd3, 0);
    put(1, 0, 2'd0, 1);
    put(0, 0, 2'd0, 1);
    put(0, 1, 2'd1, 1);
    drain(0, 40, "stray");
    n_tests += 2;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL stray_frame_cnt: got %0d required 1", frame_cnt); end
    if (rd_ptr !== 9'd5) begin n_fail++; $display("FAIL stray_rd_ptr: got %0d required 5", rd_ptr); end
  endtask

`ifdef TX_RAM_READER_DROP_EN
  task automatic test_frame_drop();
    int n;
    do_reset();
    xfers = 0;
    for (int i = 0; i < 10; i++) put(i == 0, i == 9, (i == 9) ? 2'd2 : 2'd0, i < 3);
    n = 0;
    while (xfers < 3 && n < 20) begin
      step(1'b1);
      n++;
    end
    n_tests++;
    if (xfers !== 3) begin n_fail++; $display("FAIL drop_xfers: got %0d required 3", xfers); end
    @(negedge clk);
    frame_drop = 1'b1;
    tx_if.ready = 1'b0;
    hold_chk = 0;
    @(negedge clk);
    frame_drop = 1'b0;
    #1;
    n_tests++;
    if (tx_if.valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: got %b required 0", tx_if.valid); end
    repeat (30) step(1'b1);
    n_tests += 2;
    if (rd_ptr !== 9'd10) begin n_fail++; $display("FAIL drop_rd_ptr: got %0d required 10", rd_ptr); end
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_frame_cnt: got %0d required 0", frame_cnt); end
    put(1, 0, 2'd0, 1);
    put(0, 1, 2'd3, 1);
    drain(0, 40, "drop_next");
    n_tests += 2;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_next_frame_cnt: got %0d required 1", frame_cnt); end
    if (rd_ptr !== 9'd12) begin n_fail++; $display("FAIL drop_next_rd_ptr: got %0d required 12", rd_ptr); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tx_if.ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_full_wrap_backpressure();
    test_single_word_wrap();
    test_reset_midframe();
    test_truncate_random_ready();
    test_stray_word();
`ifdef TX_RAM_READER_DROP_EN
    test_frame_drop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
